// File: rtl/booth_pp_gen_pkg.sv
// Shared constants and operation encodings for the radix-4 Booth partial-product generator.
package booth_pp_gen_pkg;

    localparam int XLEN     = 32;
    localparam int PP_NUM   = 17;
    localparam int COL_NUM  = 64;
    localparam int PP_COL_W = COL_NUM * PP_NUM;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mulOp_e;

    function automatic logic opSignA(input mulOp_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic opSignB(input mulOp_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/booth_pp_gen_sel.sv
// One radix-4 Booth group: decodes a 3-bit window of the multiplier and
// produces the shifted, sign-extended partial product plus its +1 correction bit.
module booth_sel
    import booth_pp_gen_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic [2:0]      i_code,
    input  logic [XLEN:0]   i_a,
    output logic [COL_NUM-1:0] o_pp,
    output logic            o_neg
);

    logic [XLEN+1:0]    w_aPos;
    logic [XLEN+1:0]    w_a2Pos;
    logic [XLEN+1:0]    w_sel;
    logic [COL_NUM-1:0] w_selExt;

    assign w_aPos  = {i_a[XLEN], i_a};
    assign w_a2Pos = {i_a, 1'b0};

    // Negative selections use ones' complement; the missing +1 travels in o_neg.
    always_comb begin
        w_sel = '0;
        o_neg = 1'b0;
        case (i_code)
            3'b001, 3'b010: w_sel = w_aPos;
            3'b011:         w_sel = w_a2Pos;
            3'b100: begin
                w_sel = ~w_a2Pos;
                o_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_sel = ~w_aPos;
                o_neg = 1'b1;
            end
            default: w_sel = '0;
        endcase
    end

    assign w_selExt = {{(COL_NUM - XLEN - 2){w_sel[XLEN+1]}}, w_sel};
    assign o_pp     = w_selExt << (2 * IDX);

endmodule

// File: rtl/booth_pp_gen.sv
// Single-stage Booth partial-product generator: extends operands per op, decodes
// 17 Booth groups, transposes them into columns and registers behind a valid/ready stage.
module booth_pp_gen
    import booth_pp_gen_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [XLEN-1:0]       in_a,
    input  logic [XLEN-1:0]       in_b,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PP_COL_W-1:0]   pp_col,
    output logic [PP_NUM-1:0]     booth_neg,
    output logic                  out_hi
);

    mulOp_e                w_op;
    logic [XLEN:0]         w_a33;
    logic [XLEN:0]         w_b33;
    logic [XLEN+2:0]       w_yExt;
    logic [COL_NUM-1:0]    w_pp [PP_NUM];
    logic [PP_NUM-1:0]     w_neg;
    logic [PP_COL_W-1:0]   w_ppCol;
    logic                  w_accept;

    logic                  r_outValid;
    logic [PP_COL_W-1:0]   r_ppCol;
    logic [PP_NUM-1:0]     r_boothNeg;
    logic                  r_outHi;

    assign w_op   = mulOp_e'(in_op);
    assign w_a33  = {opSignA(w_op) & in_a[XLEN-1], in_a};
    assign w_b33  = {opSignB(w_op) & in_b[XLEN-1], in_b};
    // Bit 0 is y[-1]=0 and the top bit repeats y[32], so group j reads w_yExt[2j+2:2j].
    assign w_yExt = {w_b33[XLEN], w_b33, 1'b0};

    for (genvar j = 0; j < PP_NUM; j++) begin : g_sel
        booth_sel #(.IDX(j)) u_sel (
            .i_code (w_yExt[2*j+2 : 2*j]),
            .i_a    (w_a33),
            .o_pp   (w_pp[j]),
            .o_neg  (w_neg[j])
        );
    end

    always_comb begin
        w_ppCol = '0;
        for (int k = 0; k < COL_NUM; k++) begin
            for (int j = 0; j < PP_NUM; j++) begin
                w_ppCol[k*PP_NUM + j] = w_pp[j][k];
            end
        end
    end

    assign in_ready = !flush && (!r_outValid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Flush beats everything; otherwise a new accept reloads even while draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_ppCol    <= '0;
            r_boothNeg <= '0;
            r_outHi    <= 1'b0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_ppCol    <= w_ppCol;
            r_boothNeg <= w_neg;
            r_outHi    <= (w_op != OP_MUL);
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign pp_col    = r_ppCol;
    assign booth_neg = r_boothNeg;
    assign out_hi    = r_outHi;

endmodule

// File: tb/tb_booth_pp_gen.sv
// Directed and streaming checks of booth_pp_gen against an independent product model.
module tb_booth_pp_gen;

    localparam logic [1:0] MUL    = 2'b00;
    localparam logic [1:0] MULH   = 2'b01;
    localparam logic [1:0] MULHSU = 2'b10;
    localparam logic [1:0] MULHU  = 2'b11;
    localparam int         N_RND  = 10000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [1087:0] pp_col;
    logic [16:0]   booth_neg;
    logic          out_hi;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] prod;
        logic        hi;
    } expItem_t;

    expItem_t scoreQ[$];

    booth_pp_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp_col    (pp_col),
        .booth_neg (booth_neg),
        .out_hi    (out_hi)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] reconstruct(input logic [1087:0] cols, input logic [16:0] neg);
        logic [63:0] acc;
        int          cnt;
        acc = '0;
        for (int k = 0; k < 64; k++) begin
            cnt = 0;
            for (int j = 0; j < 17; j++) cnt += int'(cols[k*17 + j]);
            acc += 64'(cnt) << k;
        end
        for (int j = 0; j < 17; j++) if (neg[j]) acc += 64'(1) << (2*j);
        return acc;
    endfunction

    function automatic logic [63:0] modelProduct(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = (op == MULH || op == MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic rdy, input logic fl);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        flush     = fl;
        #1;
    endtask

    task automatic sendOne(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] expProd, input logic [16:0] expNeg);
        applyStimulus(1'b1, op, a, b, 1'b1, 1'b0);
        checkOutput({tag, "_inReady"}, 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, MUL, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_prod"}, reconstruct(pp_col, booth_neg), expProd);
        checkOutput({tag, "_hi"}, 64'(out_hi), (op == MUL) ? 64'd0 : 64'd1);
        checkOutput({tag, "_neg"}, 64'(booth_neg), 64'(expNeg));
    endtask

    initial begin
        logic [1087:0] expCols;
        int            sent;
        int            cycles;
        logic [1:0]    rOp;
        logic [31:0]   rA;
        logic [31:0]   rB;
        expItem_t      item;

        rst_n = 1'b0;
        applyStimulus(1'b0, MUL, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_ppcol", 64'(pp_col != '0), 64'd0);
        checkOutput("rst_neg", 64'(booth_neg), 64'd0);
        checkOutput("rst_hi", 64'(out_hi), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_inReady", 64'(in_ready), 64'd1);

        // 3*5: PP0=+3, PP1=+3<<2 -> columns 0,1 carry PP0, columns 2,3 carry PP1
        sendOne("mul3x5", MUL, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 17'h0);
        expCols = '0;
        expCols[0]  = 1'b1;
        expCols[17] = 1'b1;
        expCols[35] = 1'b1;
        expCols[52] = 1'b1;
        checkOutput("mul3x5_cols", 64'(pp_col == expCols), 64'd1);
        tick();
        checkOutput("mul3x5_drained", 64'(out_valid), 64'd0);

        sendOne("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 17'h00001);
        tick();
        sendOne("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 17'h00001);
        tick();
        sendOne("mulhsu", MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0002, 17'h00001);
        tick();
        sendOne("mulNeg", MUL, 32'd6, 32'hFFFF_FFFE, 64'h0000_0005_FFFF_FFF4, 17'h00001);
        tick();

        // Backpressure: X held for three cycles while Y waits
        applyStimulus(1'b1, MUL, 32'd7, 32'd9, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, MUL, 32'd11, 32'd13, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_inReady", 64'(in_ready), 64'd0);
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_hold", reconstruct(pp_col, booth_neg), 64'd63);
            tick();
        end
        applyStimulus(1'b1, MUL, 32'd11, 32'd13, 1'b1, 1'b0);
        checkOutput("release_inReady", 64'(in_ready), 64'd1);
        checkOutput("release_old", reconstruct(pp_col, booth_neg), 64'd63);
        tick();
        applyStimulus(1'b0, MUL, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("release_valid", 64'(out_valid), 64'd1);
        checkOutput("release_new", reconstruct(pp_col, booth_neg), 64'd143);
        tick();
        checkOutput("release_noDup", 64'(out_valid), 64'd0);

        // Flush kills the held op and blocks the incoming one
        applyStimulus(1'b1, MUL, 32'd2, 32'd2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, MUL, 32'd5, 32'd5, 1'b0, 1'b1);
        checkOutput("flush_preValid", 64'(out_valid), 64'd1);
        checkOutput("flush_inReady", 64'(in_ready), 64'd0);
        tick();
        applyStimulus(1'b0, MUL, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        tick();
        checkOutput("flush_notAccepted", 64'(out_valid), 64'd0);

        // Reset while an op is held
        applyStimulus(1'b1, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        checkOutput("midrst_preValid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        applyStimulus(1'b0, MUL, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_ppcol", 64'(pp_col != '0), 64'd0);
        checkOutput("midrst_neg", 64'(booth_neg), 64'd0);
        checkOutput("midrst_hi", 64'(out_hi), 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_inReady", 64'(in_ready), 64'd1);

        // Random stream with random backpressure, in-order scoreboard
        sent   = 0;
        cycles = 0;
        while ((sent < N_RND || scoreQ.size() != 0) && cycles < 40000) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            rB  = $urandom;
            applyStimulus(sent < N_RND, rOp, rA, rB, $urandom_range(0, 3) != 0, 1'b0);
            if (out_valid && out_ready) begin
                checkOutput("rnd_nonEmpty", 64'(scoreQ.size() != 0), 64'd1);
                if (scoreQ.size() != 0) begin
                    item = scoreQ.pop_front();
                    checkOutput("rnd_prod", reconstruct(pp_col, booth_neg), item.prod);
                    checkOutput("rnd_hi", 64'(out_hi), 64'(item.hi));
                end
            end
            if (in_valid && in_ready) begin
                item.prod = modelProduct(rOp, rA, rB);
                item.hi   = (rOp != MUL);
                scoreQ.push_back(item);
                sent++;
            end
            tick();
            cycles++;
        end
        checkOutput("rnd_complete", 64'(scoreQ.size() + (N_RND - sent)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_pp_gen.md
BOOTH_PP_GEN -- requirements
Module: booth_pp_gen

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: in_valid  in  1  operands/op valid.
REQ-004 SHALL have: in_ready  out  1  stage can accept.
REQ-005 SHALL have: in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have: in_a  in  32  multiplicand rs1; in_b  in  32  multiplier rs2.
REQ-007 SHALL have: flush  in  1  kill registered/incoming op.
REQ-008 SHALL have: out_valid  out  1; out_ready  in  1.
REQ-009 SHALL have: pp_col  out  1088  64 columns x 17 bits; column k = bits [17k+16:17k], bit j = partial product j bit k.
REQ-010 SHALL have: booth_neg  out  17  two's-complement +1 bit of PP j, weight 2^(2j).
REQ-011 SHALL have: out_hi  out  1  1 for MULH/MULHSU/MULHU, 0 for MUL.

Function
REQ-012 SHALL extend a to 33 bits: sign-extend for MULH/MULHSU, zero-extend otherwise; b sign-extended for MULH only, zero-extended otherwise.
REQ-013 SHALL use radix-4 Booth on b33 with y[-1]=0, y[33]=y[32]; group j (0..16) decodes y[2j+1:2j-1].
REQ-014 SHALL select per group: 000/111 -> 0, 001/010 -> +a, 011 -> +2a, 100 -> -2a, 101/110 -> -a.
REQ-015 SHALL form PP j as the 34-bit signed selection (ones' complement when negative), sign-extended, shifted left 2j, truncated to 64 bits.
REQ-016 SHALL set booth_neg[j]=1 only for negative non-zero selections; zero selections give PP=0, neg=0.
REQ-017 Invariant: sum over k of popcount(column k)*2^k plus sum of booth_neg[j]*2^(2j), mod 2^64, SHALL equal a33*b33 mod 2^64.
REQ-018 SHALL register all outputs in one pipeline stage; latency exactly 1 cycle from accept to out_valid.
REQ-019 SHALL accept on in_valid && in_ready; in_ready = !flush && (!out_valid || out_ready).
REQ-020 SHALL hold pp_col/booth_neg/out_hi stable while out_valid && !out_ready.
REQ-021 SHALL set out_valid next cycle on accept; clear it on out_ready without accept.
REQ-022 Simultaneous handshake out (out_valid&&out_ready) and accept SHALL load new data, out_valid stays 1 (full throughput).
REQ-023 flush SHALL clear out_valid next cycle and block acceptance that cycle, overriding both.
REQ-024 in_op values SHALL only affect extension and out_hi; decoding is total, no illegal op.

Reset
REQ-025 rst_n=0 at a clock edge SHALL clear out_valid, pp_col, booth_neg, out_hi to 0.
REQ-026 Reset mid-operation SHALL discard the held op; in_ready SHALL read 1 first cycle after reset release.

Structure
REQ-027 Shared package SHALL hold op encodings, XLEN=32, PP_NUM=17, COL_NUM=64.
REQ-028 SHALL instantiate one booth_sel sub-module per group (3-bit code + 33-bit a -> 64-bit PP, neg) x17; transpose and register in top.

Verification
REQ-029 MUL a=3, b=5 -> one cycle later out_valid=1, REQ-017 reconstruction = 0x000000000000000F, out_hi=0.
REQ-030 MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> reconstruction 0x0000000000000001.
REQ-031 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE00000001; MULHSU a=0xFFFFFFFE, b=0xFFFFFFFF -> 0xFFFFFFFE00000002.
REQ-032 out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs unchanged, no op lost or duplicated after release.
REQ-033 flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not accepted.
REQ-034 rst_n=0 one cycle while out_valid=1 -> all outputs 0, in_ready=1 next cycle; random 10k ops satisfy REQ-017.
